// File: rtl/score_board.sv
// ---------------------------------------------------------------------------
// score_board
//   Two-player category score table with running totals. A commit names a
//   player, a category (0-5 upper section Aces..Sixes, 6-11 Choice, 4Kind,
//   FullHouse, SStraight, LStraight, Yacht) and a score. A valid commit is
//   stored, the player's 12 entries are re-summed one per cycle, and the
//   registered total is refreshed. An invalid or repeated commit is rejected.
//
// Build option:
//   UPPER_BONUS_EN - when defined, BONUS_VALUE is added to a player's total
//                    once the upper-section sum reaches BONUS_THRESHOLD.
//                    When undefined the bonus is always 0 and the
//                    upper-section accumulator does not exist. Latency is
//                    the same either way.
//
// Ports:
//   clk                 system clock
//   reset               synchronous, active-high; discards in-flight work
//   game_clr            one-cycle request (honoured in IDLE) to clear all
//   cmd_valid/cmd_ready commit handshake (see below)
//   cmd_player          0 = P1, 1 = P2
//   cmd_cat             category index 0..11
//   cmd_score           category score 0..50
//   ack_ok / ack_err    one-cycle result pulses
//   p1_score, p2_score  registered totals
//   p1_used, p2_used    category-used bitmaps (bit k = category k)
//   all_full            all 24 categories used
//   dbg_state           current FSM state encoding
//
// Handshake: cmd_ready is high exactly in IDLE. A transfer happens on a
// rising edge where cmd_valid && cmd_ready && !game_clr; player, category
// and score are latched on that edge. The requester holds cmd_valid until
// it sees cmd_ready; cmd_valid outside IDLE has no effect. Each accepted
// transfer produces exactly one ack_ok or ack_err pulse unless reset
// intervenes.
//
// Timing from a transfer on cycle N: CHECK N+1, ERR (ack_err) or WRITE
// N+2, SUM N+3..N+14, DONE (ack_ok) N+15, IDLE N+16.
// ---------------------------------------------------------------------------
module score_board #(
    parameter int BONUS_THRESHOLD = 63,
    parameter int BONUS_VALUE     = 35
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        game_clr,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_player,
    input  logic [3:0]  cmd_cat,
    input  logic [5:0]  cmd_score,
    output logic        ack_ok,
    output logic        ack_err,
    output logic [8:0]  p1_score,
    output logic [8:0]  p2_score,
    output logic [11:0] p1_used,
    output logic [11:0] p2_used,
    output logic        all_full,
    output logic [2:0]  dbg_state
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CHECK = 3'd1,
        ERR   = 3'd2,
        WRITE = 3'd3,
        SUM   = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t state, state_nxt;

    // Latched request
    logic        req_player;
    logic [3:0]  req_cat;
    logic [5:0]  req_score;

    // Storage
    logic [5:0]  tbl   [2][12];
    logic [11:0] used  [2];
    logic [8:0]  total_q [2];

    // Summation
    logic [3:0]  sum_idx;
    logic [8:0]  sum_acc;
    logic [5:0]  sum_entry;
    logic [8:0]  bonus;
    logic [8:0]  total;

    logic        xfer;
    logic        clr;
    logic [11:0] used_sel;
    logic [11:0] cat_mask;
    logic [11:0] used_new;
    logic        bad_req;

    // game_clr wins over a simultaneous commit, so it blocks the transfer.
    assign xfer      = cmd_valid && cmd_ready && !game_clr;
    assign clr       = game_clr && (state == IDLE);

    assign used_sel  = used[req_player];
    // Categories 12..15 shift the bit out of the 12-bit mask, so the
    // used-bit lookup below is safe for any 4-bit category.
    assign cat_mask  = 12'd1 << req_cat;
    assign used_new  = used_sel | cat_mask;
    assign bad_req   = (req_cat > 4'd11) || (req_score > 6'd50) ||
                       ((used_sel & cat_mask) != 12'd0);

    assign sum_entry = tbl[req_player][sum_idx];

`ifdef UPPER_BONUS_EN
    // Upper-section sum (categories 0-5), kept apart from the full total.
    logic [6:0] upper_acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            upper_acc <= '0;
        end else if (state == WRITE) begin
            upper_acc <= '0;
        end else if ((state == SUM) && (sum_idx < 4'd6)) begin
            upper_acc <= upper_acc + {1'b0, sum_entry};
        end
    end

    // By the last SUM cycle (index 11) the upper sum is complete.
    assign bonus = (int'(upper_acc) >= BONUS_THRESHOLD) ? 9'(BONUS_VALUE) : 9'd0;
`else
    assign bonus = 9'd0;
`endif

    // Final total formed during the last SUM cycle, including the entry
    // being added on that same cycle.
    assign total = sum_acc + 9'(sum_entry) + bonus;

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (xfer) state_nxt = CHECK;
            CHECK:   state_nxt = bad_req ? ERR : WRITE;
            ERR:     state_nxt = IDLE;
            WRITE:   state_nxt = SUM;
            SUM:     if (sum_idx == 4'd11) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign cmd_ready = (state == IDLE);
    assign ack_ok    = (state == DONE);
    assign ack_err   = (state == ERR);
    assign dbg_state = state;

    // ---------------- Datapath ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            req_player <= 1'b0;
            req_cat    <= '0;
            req_score  <= '0;
            sum_idx    <= '0;
            sum_acc    <= '0;
            all_full   <= 1'b0;
            for (int p = 0; p < 2; p++) begin
                used[p]    <= '0;
                total_q[p] <= '0;
                for (int c = 0; c < 12; c++) begin
                    tbl[p][c] <= '0;
                end
            end
        end else begin
            if (xfer) begin
                req_player <= cmd_player;
                req_cat    <= cmd_cat;
                req_score  <= cmd_score;
            end

            if (clr) begin
                all_full <= 1'b0;
                for (int p = 0; p < 2; p++) begin
                    used[p]    <= '0;
                    total_q[p] <= '0;
                    for (int c = 0; c < 12; c++) begin
                        tbl[p][c] <= '0;
                    end
                end
            end

            if (state == WRITE) begin
                // req_cat is known to be 0..11 here: CHECK rejected the rest.
                tbl[req_player][req_cat] <= req_score;
                used[req_player]         <= used_new;
                all_full                 <= (&used_new) && (&used[~req_player]);
                sum_idx                  <= '0;
                sum_acc                  <= '0;
            end else if (state == SUM) begin
                sum_acc <= sum_acc + 9'(sum_entry);
                sum_idx <= sum_idx + 4'd1;
                if (sum_idx == 4'd11) begin
                    total_q[req_player] <= total;
                end
            end
        end
    end

    assign p1_score = total_q[0];
    assign p2_score = total_q[1];
    assign p1_used  = used[0];
    assign p2_used  = used[1];

endmodule

// File: tb/tb_score_board.sv
// ---------------------------------------------------------------------------
// tb_score_board
//   Directed bench for score_board. Expected totals are hand-computed from
//   the stimulus; the bonus term follows UPPER_BONUS_EN (default 63/35).
// ---------------------------------------------------------------------------
module tb_score_board;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic        game_clr;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_player;
  logic [3:0]  cmd_cat;
  logic [5:0]  cmd_score;
  logic        ack_ok;
  logic        ack_err;
  logic [8:0]  p1_score;
  logic [8:0]  p2_score;
  logic [11:0] p1_used;
  logic [11:0] p2_used;
  logic        all_full;
  logic [2:0]  dbg_state;

  always #10 clk = ~clk;

`ifdef UPPER_BONUS_EN
  localparam int BONUS = 35;
`else
  localparam int BONUS = 0;
`endif

  int checks = 0;
  int errors = 0;

  score_board dut (
    .clk        (clk),
    .reset      (reset),
    .game_clr   (game_clr),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_player (cmd_player),
    .cmd_cat    (cmd_cat),
    .cmd_score  (cmd_score),
    .ack_ok     (ack_ok),
    .ack_err    (ack_err),
    .p1_score   (p1_score),
    .p2_score   (p2_score),
    .p1_used    (p1_used),
    .p2_used    (p2_used),
    .all_full   (all_full),
    .dbg_state  (dbg_state)
  );

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Issue one commit and watch cycles N+1..N+16 for the acknowledge.
  task automatic commit(input string tag, input logic pl, input logic [3:0] cat,
                        input logic [5:0] sc, input bit exp_ok, output int af3);
    int wait_n, ok_n, err_n, ok_at, err_at, rdy_end;
    cmd_player = pl;
    cmd_cat    = cat;
    cmd_score  = sc;
    cmd_valid  = 1'b1;
    wait_n = 0;
    while (!cmd_ready && wait_n < 40) begin
      tick();
      wait_n++;
    end
    chk({tag, "_ready_wait"}, int'(wait_n < 40), 1);
    tick();
    cmd_valid = 1'b0;
    ok_n = 0; err_n = 0; ok_at = -1; err_at = -1; af3 = 0; rdy_end = 0;
    for (int c = 1; c <= 16; c++) begin
      if (ack_ok)  begin ok_n++;  ok_at  = c; end
      if (ack_err) begin err_n++; err_at = c; end
      if (c == 3)  af3 = int'(all_full);
      if (c == 16) rdy_end = int'(cmd_ready);
      tick();
    end
    chk({tag, "_ok_pulses"},  ok_n,  exp_ok ? 1 : 0);
    chk({tag, "_err_pulses"}, err_n, exp_ok ? 0 : 1);
    if (exp_ok) chk({tag, "_ok_cycle"}, ok_at, 15);
    else        chk({tag, "_err_cycle"}, err_at, 2);
    chk({tag, "_ready_after"}, rdy_end, 1);
  endtask

  // ---------------- directed sequence ----------------
  int af3;
  int acks;
  int exp_p2 [6] = '{4, 12, 24, 40, 50, 68 + BONUS};
  int sc_p2  [6] = '{4, 8, 12, 16, 10, 18};
  int maxv   [12] = '{5, 10, 15, 20, 25, 30, 30, 30, 30, 15, 30, 50};

  initial begin
    reset = 1'b1; game_clr = 1'b0; cmd_valid = 1'b0;
    cmd_player = 1'b0; cmd_cat = '0; cmd_score = '0;
    repeat (3) tick();
    reset = 1'b0;

    // Reset state
    chk("rst_ready",  int'(cmd_ready), 1);
    chk("rst_ack_ok", int'(ack_ok), 0);
    chk("rst_ack_err", int'(ack_err), 0);
    chk("rst_all_full", int'(all_full), 0);
    chk("rst_p1_score", int'(p1_score), 0);
    chk("rst_p2_score", int'(p2_score), 0);
    chk("rst_p1_used", int'(p1_used), 0);
    chk("rst_p2_used", int'(p2_used), 0);

    // First commit: P1 Sixes = 30
    commit("p1c5", 1'b0, 4'd5, 6'd30, 1'b1, af3);
    chk("p1c5_score", int'(p1_score), 30);
    chk("p1c5_used",  int'(p1_used), 12'h020);
    chk("p1c5_p2",    int'(p2_score), 0);

    // Rejections: repeat category, bad category, bad score
    commit("p1c5_rep", 1'b0, 4'd5, 6'd12, 1'b0, af3);
    chk("rep_score", int'(p1_score), 30);
    chk("rep_used",  int'(p1_used), 12'h020);
    commit("cat12", 1'b0, 4'd12, 6'd5, 1'b0, af3);
    commit("sc51",  1'b1, 4'd0, 6'd51, 1'b0, af3);
    chk("bad_p1_used", int'(p1_used), 12'h020);
    chk("bad_p2_used", int'(p2_used), 0);
    chk("bad_p2_score", int'(p2_score), 0);

    // P2 upper section, running totals; bonus appears with the last one
    for (int k = 0; k < 6; k++) begin
      commit("p2_upper", 1'b1, 4'(k), 6'(sc_p2[k]), 1'b1, af3);
      chk("p2_upper_score", int'(p2_score), exp_p2[k]);
    end
    chk("p2_upper_used", int'(p2_used), 12'h03F);
    chk("p2_upper_p1",   int'(p1_score), 30);

    // Score exactly 50 is accepted (Yacht)
    commit("p2c11", 1'b1, 4'd11, 6'd50, 1'b1, af3);
    chk("p2c11_score", int'(p2_score), 118 + BONUS);
    chk("p2c11_used",  int'(p2_used), 12'h83F);

    // game_clr together with cmd_valid in IDLE: clear, no transfer
    game_clr = 1'b1; cmd_valid = 1'b1;
    cmd_player = 1'b0; cmd_cat = 4'd0; cmd_score = 6'd1;
    tick();
    game_clr = 1'b0; cmd_valid = 1'b0;
    chk("clr_ready",    int'(cmd_ready), 1);
    chk("clr_p1_score", int'(p1_score), 0);
    chk("clr_p2_score", int'(p2_score), 0);
    chk("clr_p1_used",  int'(p1_used), 0);
    chk("clr_p2_used",  int'(p2_used), 0);
    acks = 0;
    for (int c = 0; c < 20; c++) begin
      if (ack_ok || ack_err) acks++;
      tick();
    end
    chk("clr_no_ack", acks, 0);
    // Old P2 entries must be gone: a single new entry is the whole total
    commit("after_clr", 1'b1, 4'd0, 6'd3, 1'b1, af3);
    chk("after_clr_p2", int'(p2_score), 3);

    // Reset during SUM discards the commit
    cmd_player = 1'b0; cmd_cat = 4'd1; cmd_score = 6'd9; cmd_valid = 1'b1;
    tick();
    cmd_valid = 1'b0;
    repeat (5) tick();
    reset = 1'b1;
    acks = 0;
    tick();
    reset = 1'b0;
    tick();
    chk("rst_sum_ready", int'(cmd_ready), 1);
    for (int c = 0; c < 20; c++) begin
      if (ack_ok || ack_err) acks++;
      tick();
    end
    chk("rst_sum_no_ack",  acks, 0);
    chk("rst_sum_p1",      int'(p1_score), 0);
    chk("rst_sum_p2",      int'(p2_score), 0);
    chk("rst_sum_p1_used", int'(p1_used), 0);

    // Fill every category of both players with its maximum value
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < 12; k++) begin
        if (p == 1 && k == 11) chk("pre_full", int'(all_full), 0);
        commit("fill", 1'(p), 4'(k), 6'(maxv[k]), 1'b1, af3);
      end
    end
    chk("full_at_n3", af3, 1);
    chk("full_flag",  int'(all_full), 1);
    chk("full_p1",    int'(p1_score), 290 + BONUS);
    chk("full_p2",    int'(p2_score), 290 + BONUS);
    chk("full_p1_used", int'(p1_used), 12'hFFF);
    chk("full_p2_used", int'(p2_used), 12'hFFF);
    commit("full_rep", 1'b0, 4'd3, 6'd1, 1'b0, af3);
    chk("full_rep_p1", int'(p1_score), 290 + BONUS);

    // Plain game_clr drops all_full
    game_clr = 1'b1;
    tick();
    game_clr = 1'b0;
    chk("clr2_all_full", int'(all_full), 0);
    chk("clr2_p1_score", int'(p1_score), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
